// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package lsu_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    // Size encoding 3 is treated like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = offset[0];
            default:   is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store replication and mask, load extraction and extension,
// and the alignment check applied to an incoming request.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        wen,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  chk_size,
    input  logic [1:0]  chk_offset,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_wmask,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = mem_rdata >> {offset, 3'b000};
        lane_wdata = wdata;
        lane_wmask = 4'b1111;
        load_data  = mem_rdata;
        case (size)
            SIZE_BYTE: begin
                lane_wdata = {4{wdata[7:0]}};
                lane_wmask = 4'b0001 << offset;
                load_data  = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                lane_wdata = {2{wdata[15:0]}};
                lane_wmask = 4'b0011 << offset;
                load_data  = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
        if (!wen) begin
            lane_wmask = 4'b0000;
        end
        misaligned = is_misaligned(chk_size, chk_offset);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one bus transaction per accepted request, with
// misalignment trapping, bus timeout and dropping of late (stale) responses.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsu_reqValid,
    input  logic        lsu_wen,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_respValid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_reqValid,
    input  logic        mem_reqReady,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        wen_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        stale_q, stale_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        capture;

    logic [31:0] load_data;
    logic        misaligned;
    logic        timeout;
    logic        resp_ok;

    lsu_align u_align (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .wen         (wen_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .mem_rdata   (mem_rdata),
        .chk_size    (lsu_size),
        .chk_offset  (lsu_addr[1:0]),
        .lane_wdata  (mem_wdata),
        .lane_wmask  (mem_wmask),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    // >= rather than == so a handshake taken on the threshold cycle still times out in WAIT.
    assign timeout = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_ok = mem_respValid && !stale_q;

    assign mem_reqValid  = (state_q == LSU_REQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = wen_q;
    assign lsu_respValid = (state_q == LSU_RESP);
    assign lsu_rdata     = rdata_q;
    assign lsu_err       = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stale_d = stale_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        capture = 1'b0;

        if (mem_respValid && stale_q) begin
            stale_d = 1'b0;
        end

        unique case (state_q)
            LSU_IDLE: begin
                if (lsu_reqValid) begin
                    capture = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = LSU_RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_reqReady) begin
                    state_d = LSU_WAIT;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (resp_ok) begin
                    if (!wen_q) begin
                        rdata_d = load_data;
                    end
                    state_d = LSU_RESP;
                end else if (timeout) begin
                    // The bus still owes a response; drop it when it shows up.
                    err_d   = 1'b1;
                    stale_d = 1'b1;
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            stale_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stale_q <= stale_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                wen_q   <= lsu_wen;
                uns_q   <= lsu_unsigned;
                size_q  <= lsu_size;
                addr_q  <= lsu_addr;
                wdata_q <= lsu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized transactions
// compared against an arithmetic reference model of lane handling and timing.
module tb_lsu_ctrl;

    localparam int unsigned TO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsu_reqValid, lsu_wen, lsu_unsigned;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_respValid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid, mem_reqReady, mem_wen, mem_respValid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int errors = 0;
    int checks = 0;

    lsu_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_wen       (lsu_wen),
        .lsu_size      (lsu_size),
        .lsu_unsigned  (lsu_unsigned),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .lsu_err       (lsu_err),
        .mem_reqValid  (mem_reqValid),
        .mem_reqReady  (mem_reqReady),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_respValid (mem_respValid),
        .mem_rdata     (mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: lane arithmetic straight from the access rules.
    function automatic bit m_mis(input logic [1:0] size, input logic [31:0] addr);
        int nb = 1 << size;
        return (addr % nb) != 0;
    endfunction

    function automatic logic [3:0] m_mask(input logic wen, input logic [1:0] size,
                                          input logic [31:0] addr);
        int m;
        if (!wen) return 4'b0000;
        m = ((1 << (1 << size)) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (size == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] bus);
        int nbits = 8 * (1 << size);
        logic [63:0] v;
        if (nbits == 32) return bus;
        v = {32'd0, bus} >> (8 * (addr % 4));
        v = v % (64'd1 << nbits);
        if (!uns && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
        return v[31:0];
    endfunction

    // One request held until its response. The bus raises ready from REQ cycle
    // 1+delay, answers lag cycles after the handshake (if respond), and optionally
    // pulses a junk response at cycle stale_at.
    task automatic run_txn(input string tag, input logic wen, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] bus, input int delay, input int lag,
                           input bit respond, input int stale_at);
        int hs = 0;
        int hs_cyc = -1;
        int reqv = 0;
        bit done = 0;
        bit mis = m_mis(size, addr);
        bit hs_ok = !mis && (delay <= int'(TO) - 1);
        bit exp_err = mis || !hs_ok || !respond;
        int exp_cyc = mis ? 1 : (exp_err ? int'(TO) + 1 : 2 + delay + lag);
        logic [31:0] exp_rd = exp_err ? 32'd0 : m_load(size, uns, addr, bus);
        bit real_resp, junk_resp;

        @(negedge clock);
        lsu_reqValid = 1'b1;
        lsu_wen = wen;
        lsu_size = size;
        lsu_unsigned = uns;
        lsu_addr = addr;
        lsu_wdata = wd;
        mem_reqReady = 1'b0;
        mem_respValid = 1'b0;
        @(posedge clock);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clock);
            real_resp = respond && hs_cyc >= 0 && c == hs_cyc + lag;
            junk_resp = (c == stale_at);
            mem_respValid = real_resp || junk_resp;
            mem_rdata = real_resp ? bus : $urandom;
            if (mem_reqValid) begin
                reqv++;
                check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
                check({tag, ".wen"}, {31'd0, mem_wen}, {31'd0, wen});
                check({tag, ".wmask"}, {28'd0, mem_wmask}, {28'd0, m_mask(wen, size, addr)});
                if (wen) check({tag, ".wdata"}, mem_wdata, m_wdata(size, wd));
            end
            mem_reqReady = (c >= 1 + delay);
            if (mem_reqValid && mem_reqReady) begin
                hs++;
                hs_cyc = c;
            end
            if (lsu_respValid) begin
                done = 1;
                check({tag, ".cycle"}, 32'(c), 32'(exp_cyc));
                check({tag, ".err"}, {31'd0, lsu_err}, {31'd0, exp_err});
                if (!wen || exp_err) check({tag, ".rdata"}, lsu_rdata, exp_rd);
            end
        end
        check({tag, ".resp_seen"}, 32'(done), 32'd1);
        check({tag, ".handshakes"}, 32'(hs), hs_ok ? 32'd1 : 32'd0);
        if (mis) check({tag, ".no_bus"}, 32'(reqv), 32'd0);
        // reqValid stayed high through RESP; the following IDLE must not show a new request.
        lsu_reqValid = 1'b0;
        mem_reqReady = 1'b0;
        mem_respValid = 1'b0;
        @(negedge clock);
        check({tag, ".idle_after"}, {30'd0, mem_reqValid, lsu_respValid}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".resp"}, {30'd0, lsu_respValid, lsu_err}, 32'd0);
        check({tag, ".rdata"}, lsu_rdata, 32'd0);
        check({tag, ".memctl"}, {27'd0, mem_reqValid, mem_wmask}, 32'd0);
        check({tag, ".memaddr"}, mem_addr, 32'd0);
        check({tag, ".memwdata"}, {mem_wdata[31:1], mem_wen}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        lsu_reqValid = 1'b0;
        lsu_wen = 1'b0;
        lsu_size = 2'd0;
        lsu_unsigned = 1'b0;
        lsu_addr = 32'd0;
        lsu_wdata = 32'd0;
        mem_reqReady = 1'b0;
        mem_respValid = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;

        run_txn("sw", 1, 2'd2, 0, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 1, 1, -1);
        run_txn("sb", 1, 2'd0, 0, 32'h203, 32'h0000_00A5, 32'h0, 0, 1, 1, -1);
        run_txn("lh", 0, 2'd1, 0, 32'h102, 32'h0, 32'h8001_1234, 0, 1, 1, -1);
        run_txn("lhu", 0, 2'd1, 1, 32'h102, 32'h0, 32'h8001_1234, 0, 1, 1, -1);
        run_txn("lb", 0, 2'd0, 0, 32'h101, 32'h0, 32'h8001_1234, 0, 1, 1, -1);
        run_txn("lw_mis", 0, 2'd2, 0, 32'h106, 32'h0, 32'h0, 0, 1, 1, -1);
        run_txn("sh_stall", 1, 2'd1, 0, 32'h202, 32'h0000_C3D4, 32'h0, 5, 1, 1, -1);

        // Timeout in WAIT, late response dropped while idle, then a clean load.
        run_txn("to_wait", 0, 2'd2, 0, 32'h108, 32'h0, 32'h0, 0, 1, 0, -1);
        repeat (2) @(negedge clock);
        mem_respValid = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        mem_respValid = 1'b0;
        check("stale_idle", {30'd0, mem_reqValid, lsu_respValid}, 32'd0);
        run_txn("lw_after", 0, 2'd2, 0, 32'h10C, 32'h0, 32'h1122_3344, 0, 1, 1, -1);

        // Timeout in REQ owes nothing, so the next response is genuine.
        run_txn("to_req", 0, 2'd2, 0, 32'h110, 32'h0, 32'h0, 100, 1, 1, -1);
        run_txn("lw_noStale", 0, 2'd2, 0, 32'h114, 32'h0, 32'h5566_7788, 0, 1, 1, -1);

        // Stale response landing in the next transaction's WAIT is discarded.
        run_txn("to_wait2", 0, 2'd2, 0, 32'h118, 32'h0, 32'h0, 0, 1, 0, -1);
        run_txn("lw_staleWait", 0, 2'd0, 1, 32'h11B, 32'h0, 32'h9ABC_DEF0, 0, 3, 1, 2);

        // Async reset mid-WAIT.
        @(negedge clock);
        lsu_reqValid = 1'b1;
        lsu_wen = 1'b0;
        lsu_size = 2'd2;
        lsu_addr = 32'h300;
        mem_reqReady = 1'b1;
        repeat (2) @(negedge clock);
        lsu_reqValid = 1'b0;
        mem_reqReady = 1'b0;
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_rst");
        @(negedge clock);
        reset = 1'b0;
        run_txn("lw_postRst", 0, 2'd2, 0, 32'h304, 32'h0, 32'hCAFE_F00D, 0, 1, 1, -1);

        for (int i = 0; i < 40; i++) begin
            run_txn("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 2)), 1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
